// File: rtl/inst_fetch_queue.sv
// Fetch stage of the RV64I pipeline.
// Issues in-order requests to instruction memory using a credit scheme, so
// every response is guaranteed a slot in the instruction buffer. Returned
// words are paired with their PC, which is taken from a small tag queue,
// and handed to decode in order. A redirect flushes the buffer and marks
// every outstanding request as stale. Stale responses are then discarded
// as they return.
module inst_fetch_queue #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_inst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [63:0] id_pc,
    output logic [31:0] id_inst
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    // Control state
    logic [63:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0] out_cnt_q,  out_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [PTR_W-1:0] head_q,     head_d;
    logic [PTR_W-1:0] tail_q,     tail_d;
    logic [PTR_W-1:0] tag_wr_q,   tag_wr_d;
    logic [PTR_W-1:0] tag_rd_q,   tag_rd_d;

    // Storage; never read before it is written, so it carries no reset
    logic [63:0] fifo_pc_q   [FIFO_DEPTH];
    logic [31:0] fifo_inst_q [FIFO_DEPTH];
    logic [63:0] tag_pc_q    [FIFO_DEPTH];

    logic [CNT_W:0] credit_sum;
    logic           req_fire;
    logic           rsp_fire;
    logic           pop;
    logic           drop_rsp;
    logic           push;
    logic [63:0]    rsp_pc;

    // The low two bits of a redirect target are forced to zero.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // A request is only issued when buffered plus in-flight entries leave room,
    // so a returning response never finds the buffer full.
    assign credit_sum     = {1'b0, fifo_cnt_q} + {1'b0, out_cnt_q};
    assign imem_req_valid = !rst && (credit_sum < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;

    assign req_fire = imem_req_valid & imem_req_ready;
    assign rsp_fire = imem_rsp_valid;
    assign id_valid = (fifo_cnt_q != '0);
    assign pop      = id_valid & id_ready;

    // Stale responses are consumed without touching the buffer. Anything
    // that returns during a redirect cycle is stale by definition.
    assign drop_rsp = rsp_fire & (drop_cnt_q != '0);
    assign push     = rsp_fire & !drop_rsp & !redirect_valid;
    assign rsp_pc   = tag_pc_q[tag_rd_q];

    // The head is only meaningful while valid. Outputs read zero otherwise,
    // including immediately after reset.
    assign id_pc   = id_valid ? fifo_pc_q[head_q]   : 64'h0;
    assign id_inst = id_valid ? fifo_inst_q[head_q] : 32'h0;

    // Next-state logic for fetch PC, counters and pointers
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        fifo_cnt_d = fifo_cnt_q;
        drop_cnt_d = drop_cnt_q;
        head_d     = head_q;
        tail_d     = tail_q;

        // Outstanding count and tag queue run independently of redirects.
        // Every accepted request, stale or not, gets exactly one response.
        out_cnt_d = out_cnt_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
        tag_wr_d  = req_fire ? tag_wr_q + PTR_W'(1) : tag_wr_q;
        tag_rd_d  = rsp_fire ? tag_rd_q + PTR_W'(1) : tag_rd_q;

        if (redirect_valid) begin
            // Flush the buffer and ignore any pop. Every request still
            // outstanding after this cycle is stale, including one accepted now.
            fifo_cnt_d = '0;
            head_d     = '0;
            tail_d     = '0;
            drop_cnt_d = out_cnt_d;
            fetch_pc_d = {redirect_pc[63:2], 2'b00};
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
            end
            if (drop_rsp) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            fifo_cnt_q <= '0;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            fifo_cnt_q <= fifo_cnt_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
        end
    end

    // Buffer and PC tag storage writes
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[tail_q]   <= rsp_pc;
            fifo_inst_q[tail_q] <= imem_rsp_inst;
        end
        if (req_fire) begin
            tag_pc_q[tag_wr_q] <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed testbench for inst_fetch_queue (FIFO_DEPTH=4, RESET_PC=0).
// The instruction memory returns inst = {addr[23:0], 8'h13}.
// It answers one response per cycle, in order, one cycle after each accept,
// unless responses are held back.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_inst = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [63:0] id_pc;
    logic [31:0] id_inst;

    int errors = 0;
    int checks = 0;

    logic        mem_hold = 1'b0;
    logic [63:0] pend_q[$];
    logic [63:0] req_log[$];
    logic [63:0] pop_pc_log[$];
    logic [31:0] pop_inst_log[$];

    inst_fetch_queue #(
        .RESET_PC  (64'h0),
        .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_inst (imem_rsp_inst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_pc         (id_pc),
        .id_inst       (id_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return {a[23:0], 8'h13};
    endfunction

    // One clock: sample handshakes on the falling edge, then update the
    // memory model and the logs just after the rising edge.
    task automatic tick();
        logic        rf;
        logic        pf;
        logic [63:0] ra;
        logic [63:0] pp;
        logic [31:0] pi;
        @(negedge clk);
        rf = imem_req_valid & imem_req_ready;
        ra = imem_req_addr;
        pf = id_valid & id_ready & !redirect_valid;
        pp = id_pc;
        pi = id_inst;
        @(posedge clk);
        #1;
        if (rf) begin
            pend_q.push_back(ra);
            req_log.push_back(ra);
        end
        if (pf) begin
            pop_pc_log.push_back(pp);
            pop_inst_log.push_back(pi);
        end
        if (!mem_hold && pend_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_inst  = inst_of(pend_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_inst  = 32'h0;
        end
    endtask

    task automatic clear_logs();
        pend_q.delete();
        req_log.delete();
        pop_pc_log.delete();
        pop_inst_log.delete();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_inst  = 32'h0;
        imem_req_ready = 1'b0;
        id_ready       = 1'b0;
        mem_hold       = 1'b0;
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        for (int i = 0; i < budget && pop_pc_log.size() < n; i++) tick();
        checks++;
        if (pop_pc_log.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pops, required %0d", name, pop_pc_log.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b required 0", imem_req_valid); end
        checks++; if (imem_req_addr !== 64'h0) begin errors++; $display("FAIL rst_req_addr: got %h required 0", imem_req_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid: got %b required 0", id_valid); end
        checks++; if (id_pc !== 64'h0) begin errors++; $display("FAIL rst_id_pc: got %h required 0", id_pc); end
        checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL rst_id_inst: got %h required 0", id_inst); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_release_req_valid: got %b required 1", imem_req_valid); end
    endtask

    task automatic test_basic_fetch();
        do_reset();
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        checks++; if (imem_req_addr !== 64'h0) begin errors++; $display("FAIL basic_first_addr: got %h required 0", imem_req_addr); end
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL basic_no_bypass: got %b required 0", id_valid); end
        tick();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL basic_latency_valid: got %b required 1", id_valid); end
        checks++; if (id_pc !== 64'h0) begin errors++; $display("FAIL basic_latency_pc: got %h required 0", id_pc); end
        checks++; if (id_inst !== 32'h00000013) begin errors++; $display("FAIL basic_latency_inst: got %h required 00000013", id_inst); end
        wait_pops(3, 20, "basic");
        checks++; if (req_log[1] !== 64'h4) begin errors++; $display("FAIL basic_req1: got %h required 4", req_log[1]); end
        checks++; if (req_log[2] !== 64'h8) begin errors++; $display("FAIL basic_req2: got %h required 8", req_log[2]); end
        checks++; if (pop_pc_log[0] !== 64'h0) begin errors++; $display("FAIL basic_pop0_pc: got %h required 0", pop_pc_log[0]); end
        checks++; if (pop_pc_log[1] !== 64'h4) begin errors++; $display("FAIL basic_pop1_pc: got %h required 4", pop_pc_log[1]); end
        checks++; if (pop_pc_log[2] !== 64'h8) begin errors++; $display("FAIL basic_pop2_pc: got %h required 8", pop_pc_log[2]); end
        checks++; if (pop_inst_log[1] !== 32'h00000413) begin errors++; $display("FAIL basic_pop1_inst: got %h required 00000413", pop_inst_log[1]); end
        checks++; if (pop_inst_log[2] !== 32'h00000813) begin errors++; $display("FAIL basic_pop2_inst: got %h required 00000813", pop_inst_log[2]); end
    endtask

    task automatic test_backpressure();
        do_reset();
        imem_req_ready = 1'b1;
        id_ready       = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i >= 2) begin
                checks++;
                if (id_pc !== 64'h0) begin errors++; $display("FAIL bp_head_stable_%0d: got %h required 0", i, id_pc); end
            end
        end
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL bp_id_valid: got %b required 1", id_valid); end
        checks++; if (id_inst !== 32'h00000013) begin errors++; $display("FAIL bp_id_inst: got %h required 00000013", id_inst); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_stalled: got %b required 0", imem_req_valid); end
        checks++; if (req_log.size() !== 4) begin errors++; $display("FAIL bp_req_count: got %0d required 4", req_log.size()); end
        id_ready = 1'b1;
        wait_pops(5, 30, "bp_drain");
        checks++; if (pop_pc_log[0] !== 64'h0) begin errors++; $display("FAIL bp_pop0: got %h required 0", pop_pc_log[0]); end
        checks++; if (pop_pc_log[1] !== 64'h4) begin errors++; $display("FAIL bp_pop1: got %h required 4", pop_pc_log[1]); end
        checks++; if (pop_pc_log[2] !== 64'h8) begin errors++; $display("FAIL bp_pop2: got %h required 8", pop_pc_log[2]); end
        checks++; if (pop_pc_log[3] !== 64'hC) begin errors++; $display("FAIL bp_pop3: got %h required c", pop_pc_log[3]); end
        checks++; if (pop_inst_log[3] !== 32'h00000C13) begin errors++; $display("FAIL bp_pop3_inst: got %h required 00000c13", pop_inst_log[3]); end
        checks++; if (pop_pc_log[4] !== 64'h10) begin errors++; $display("FAIL bp_pop4: got %h required 10", pop_pc_log[4]); end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        mem_hold       = 1'b1;
        tick();
        tick();
        imem_req_ready = 1'b0;
        checks++; if (req_log.size() !== 2) begin errors++; $display("FAIL rdi_inflight: got %0d required 2", req_log.size()); end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1000;
        mem_hold       = 1'b0;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        checks++; if (imem_req_addr !== 64'h1000) begin errors++; $display("FAIL rdi_new_addr: got %h required 1000", imem_req_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rdi_flushed: got %b required 0", id_valid); end
        wait_pops(2, 20, "rdi");
        checks++; if (pop_pc_log[0] !== 64'h1000) begin errors++; $display("FAIL rdi_pop0_pc: got %h required 1000", pop_pc_log[0]); end
        checks++; if (pop_inst_log[0] !== 32'h00100013) begin errors++; $display("FAIL rdi_pop0_inst: got %h required 00100013", pop_inst_log[0]); end
        checks++; if (pop_pc_log[1] !== 64'h1004) begin errors++; $display("FAIL rdi_pop1_pc: got %h required 1004", pop_pc_log[1]); end
        checks++; if (req_log[2] !== 64'h1000) begin errors++; $display("FAIL rdi_req2: got %h required 1000", req_log[2]); end
    endtask

    task automatic test_redirect_collision();
        do_reset();
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        tick();
        tick();
        // Here a pop, a response and a request acceptance all coincide.
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL rdc_pre_valid: got %b required 1", id_valid); end
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rdc_pre_req: got %b required 1", imem_req_valid); end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2000;
        tick();
        redirect_valid = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rdc_flushed: got %b required 0", id_valid); end
        checks++; if (imem_req_addr !== 64'h2000) begin errors++; $display("FAIL rdc_new_addr: got %h required 2000", imem_req_addr); end
        wait_pops(2, 20, "rdc");
        checks++; if (pop_pc_log[0] !== 64'h2000) begin errors++; $display("FAIL rdc_pop0_pc: got %h required 2000", pop_pc_log[0]); end
        checks++; if (pop_inst_log[0] !== 32'h00200013) begin errors++; $display("FAIL rdc_pop0_inst: got %h required 00200013", pop_inst_log[0]); end
        checks++; if (pop_pc_log[1] !== 64'h2004) begin errors++; $display("FAIL rdc_pop1_pc: got %h required 2004", pop_pc_log[1]); end
        checks++; if (req_log[2] !== 64'h8) begin errors++; $display("FAIL rdc_req2: got %h required 8", req_log[2]); end
        checks++; if (req_log[3] !== 64'h2000) begin errors++; $display("FAIL rdc_req3: got %h required 2000", req_log[3]); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_aligned: got %h required fffffffffffffffc", imem_req_addr); end
        tick();
        checks++; if (imem_req_addr !== 64'h0) begin errors++; $display("FAIL wrap_to_zero: got %h required 0", imem_req_addr); end
        wait_pops(2, 20, "wrap");
        checks++; if (pop_pc_log[0] !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_pop0_pc: got %h required fffffffffffffffc", pop_pc_log[0]); end
        checks++; if (pop_inst_log[0] !== 32'hFFFFFC13) begin errors++; $display("FAIL wrap_pop0_inst: got %h required fffffc13", pop_inst_log[0]); end
        checks++; if (pop_pc_log[1] !== 64'h0) begin errors++; $display("FAIL wrap_pop1_pc: got %h required 0", pop_pc_log[1]); end
        checks++; if (req_log[1] !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_req1: got %h required fffffffffffffffc", req_log[1]); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        imem_req_ready = 1'b1;
        id_ready       = 1'b0;
        tick();
        tick();
        tick();
        // Two entries are buffered and one request is in flight.
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL rsm_pre_valid: got %b required 1", id_valid); end
        checks++; if (imem_req_addr !== 64'hC) begin errors++; $display("FAIL rsm_pre_addr: got %h required c", imem_req_addr); end
        #2;
        rst            = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_inst  = 32'h0;
        pend_q.delete();
        #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rsm_id_valid: got %b required 0", id_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rsm_req_valid: got %b required 0", imem_req_valid); end
        checks++; if (imem_req_addr !== 64'h0) begin errors++; $display("FAIL rsm_req_addr: got %h required 0", imem_req_addr); end
        @(posedge clk);
        #1;
        clear_logs();
        rst      = 1'b0;
        id_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rsm_restart_valid: got %b required 1", imem_req_valid); end
        wait_pops(1, 20, "rsm");
        checks++; if (req_log[0] !== 64'h0) begin errors++; $display("FAIL rsm_req0: got %h required 0", req_log[0]); end
        checks++; if (pop_pc_log[0] !== 64'h0) begin errors++; $display("FAIL rsm_pop0_pc: got %h required 0", pop_pc_log[0]); end
        checks++; if (pop_inst_log[0] !== 32'h00000013) begin errors++; $display("FAIL rsm_pop0_inst: got %h required 00000013", pop_inst_log[0]); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_collision();
        test_pc_wrap();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
